// File: rtl/gpi_db_pkg.sv
// Shared types and constants for the GPI debouncer.
package gpi_db_pkg;

    typedef enum logic {
        ST_STABLE,
        ST_COUNT
    } db_state_e;

    localparam int unsigned CNT_W             = 16;
    localparam int unsigned DB_CYCLES_DEFAULT = 1000;

endpackage

// File: rtl/gpi_db_chan.sv
// One debounce channel: two-flop synchronizer, stability FSM with counter,
// and sticky rise/fall pending flags.
module gpi_db_chan
    import gpi_db_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic edge_clr,
    output logic gpi,
    output logic rise_pend,
    output logic fall_pend
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gpi_q, gpi_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gpi_d   = gpi_q;
        unique case (state_q)
            ST_STABLE: begin
                if (sync2_q != gpi_q) begin
                    // A single-cycle debounce accepts the new level immediately.
                    if (DB_CYCLES == 1) begin
                        gpi_d = sync2_q;
                    end else begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_COUNT: begin
                if (sync2_q == gpi_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    gpi_d   = sync2_q;
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Set takes priority over a same-cycle clear.
    always_comb begin
        rise_d = (~gpi_q & gpi_d) | (rise_q & ~edge_clr);
        fall_d = (gpi_q & ~gpi_d) | (fall_q & ~edge_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            gpi_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gpi_q   <= gpi_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign gpi       = gpi_q;
    assign rise_pend = rise_q;
    assign fall_pend = fall_q;

endmodule

// File: rtl/gpi_debounce.sv
// Multi-channel GPI debouncer with edge-pending flags and a gated interrupt.
module gpi_debounce
    import gpi_db_pkg::*;
#(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NUM_CH-1:0] pin_in,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    input  logic [NUM_CH-1:0] edge_clr,
    output logic [NUM_CH-1:0] gpi,
    output logic [NUM_CH-1:0] rise_pend,
    output logic [NUM_CH-1:0] fall_pend,
    output logic              irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        gpi_db_chan #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .clk      (PCLK),
            .rst_n    (PRESET),
            .pin      (pin_in[i]),
            .edge_clr (edge_clr[i]),
            .gpi      (gpi[i]),
            .rise_pend(rise_pend[i]),
            .fall_pend(fall_pend[i])
        );
    end

    assign irq = |((rise_pend & rise_en) | (fall_pend & fall_en));

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning the number of input channels.
REQ-002 SHALL have parameter DB_CYCLES, default 1000, range 1..65535, meaning the consecutive stable cycles required before the output changes.
REQ-003 SHALL have port PCLK  input  1  the single clock; all flops are on its rising edge.
REQ-004 SHALL have port PRESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pin_in  input  NUM_CH  raw asynchronous external pins.
REQ-006 SHALL have port rise_en  input  NUM_CH  per-channel rising-edge interrupt enable.
REQ-007 SHALL have port fall_en  input  NUM_CH  per-channel falling-edge interrupt enable.
REQ-008 SHALL have port edge_clr  input  NUM_CH  single-cycle write-1-to-clear of both pending flags of a channel.
REQ-009 SHALL have port gpi  output  NUM_CH  debounced level, registered, feeding the GPI peripheral gpi input.
REQ-010 SHALL have port rise_pend  output  NUM_CH  sticky rising-edge flags.
REQ-011 SHALL have port fall_pend  output  NUM_CH  sticky falling-edge flags.
REQ-012 SHALL have port irq  output  1  combinational OR of (rise_pend & rise_en) | (fall_pend & fall_en).

Function
REQ-013 SHALL pass each pin_in bit through a two-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-014 SHALL run one FSM per channel with states ST_STABLE and ST_COUNT and a 16-bit counter cnt.
REQ-015 ST_STABLE, sync2 != gpi: SHALL go to ST_COUNT with cnt <= 1; if DB_CYCLES == 1, SHALL instead update gpi on that edge and stay in ST_STABLE.
REQ-016 ST_COUNT, sync2 == gpi (glitch): SHALL return to ST_STABLE with cnt <= 0 and gpi unchanged.
REQ-017 ST_COUNT, sync2 != gpi, cnt == DB_CYCLES-1: SHALL set gpi <= sync2, cnt <= 0, and go to ST_STABLE.
REQ-018 ST_COUNT, sync2 != gpi, otherwise: SHALL increment cnt; cnt never exceeds DB_CYCLES-1 and never wraps.
REQ-019 A clean pin transition SHALL appear on gpi exactly DB_CYCLES+2 PCLK edges after the first edge that samples the new level.
REQ-020 On the edge where gpi goes 0->1, rise_pend SHALL set; on 1->0, fall_pend SHALL set.
REQ-021 edge_clr[i]=1 SHALL clear rise_pend[i] and fall_pend[i] on the next edge.
REQ-022 If a set and a clear of the same channel occur on the same edge, the set SHALL win.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be honoured on the same edge.
REQ-024 Pending flags SHALL set regardless of the enables; the enables gate irq only.

Reset
REQ-025 PRESET low SHALL immediately force sync1, sync2, gpi, rise_pend, fall_pend and cnt to 0 and every FSM to ST_STABLE, including in the middle of a count.
REQ-026 If pin_in is high at reset release, gpi SHALL rise after DB_CYCLES+2 edges and set rise_pend, as for a normal transition.

Structure
REQ-027 Package gpi_db_pkg SHALL hold the state enum db_state_e (ST_STABLE, ST_COUNT), CNT_W = 16, and DB_CYCLES_DEFAULT = 1000.
REQ-028 The per-channel synchronizer, FSM, counter and pending flags SHALL be a sub-module gpi_db_chan, instantiated NUM_CH times by a generate loop; irq SHALL be reduced at the top level.

Verification (DB_CYCLES = 4)
REQ-029 Drive pin_in[0] 0->1 and hold -> gpi[0]=1 after exactly 6 edges, rise_pend[0]=1 on the same edge, irq=1 only if rise_en[0]=1.
REQ-030 Drive pin_in[3] with a 3-cycle high glitch -> gpi[3] stays 0, rise_pend[3] stays 0, and the FSM returns to ST_STABLE.
REQ-031 Pulse edge_clr[0] on the same edge fall_pend[0] sets -> fall_pend[0]=1; pulse edge_clr[0] alone one cycle later -> both flags 0 and irq=0.
REQ-032 Assert PRESET low while cnt=2 on channel 5 -> all outputs 0 at once; after release with pin_in[5]=1 held -> gpi[5]=1 after 6 edges.
REQ-033 Toggle pin_in=8'hFF at once with rise_en=8'h0F -> gpi=8'hFF and rise_pend=8'hFF on the same edge, and irq=1.
